sb_rx_fsm: RTL



---
 rtl/sb_rx_fsm_if.sv | 28 ++
 rtl/sb_rx_fsm.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/sb_rx_fsm_if.sv
// Sideband RX bundle: serial input, FIFO write port and status/error outputs.
interface sb_rx_fsm_if #(
    parameter int unsigned PKT_WIDTH = 64,
    parameter int unsigned CNT_W     = 8
);
    logic                 i_bit_valid;
    logic                 i_ser_data;
    logic                 i_fifo_full;
    logic                 o_fifo_wr_en;
    logic [PKT_WIDTH-1:0] o_fifo_wdata;
    logic                 o_rx_busy;
    logic                 o_gap_err;
    logic                 o_trunc_err;
    logic                 o_ovf_err;
    logic [CNT_W-1:0]     o_pkt_cnt;

    modport slave (
        input  i_bit_valid, i_ser_data, i_fifo_full,
        output o_fifo_wr_en, o_fifo_wdata, o_rx_busy,
        output o_gap_err, o_trunc_err, o_ovf_err, o_pkt_cnt
    );

    modport master (
        output i_bit_valid, i_ser_data, i_fifo_full,
        input  o_fifo_wr_en, o_fifo_wdata, o_rx_busy,
        input  o_gap_err, o_trunc_err, o_ovf_err, o_pkt_cnt
    );
endinterface

// File: rtl/sb_rx_fsm.sv
// Sideband RX framer: deserialises LSB-first packets, enforces the idle gap,
// pushes complete packets to the RX FIFO and flags gap/truncation/overflow.
module sb_rx_fsm #(
    parameter int unsigned PKT_WIDTH = 64,
    parameter int unsigned GAP_UI    = 32,
    parameter int unsigned CNT_W     = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    sb_rx_fsm_if.slave  sb
);

    localparam int unsigned BIT_W = $clog2(PKT_WIDTH + 1);
    localparam int unsigned GAP_W = $clog2(GAP_UI + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        GAP     = 2'd2
    } state_e;

    state_e               state_q,     state_d;
    logic [PKT_WIDTH-1:0] shift_q,     shift_d;
    logic [BIT_W-1:0]     bit_cnt_q,   bit_cnt_d;
    logic [GAP_W-1:0]     stall_q,     stall_d;
    logic [GAP_W-1:0]     gap_cnt_q,   gap_cnt_d;
    logic                 wr_en_q,     wr_en_d;
    logic [PKT_WIDTH-1:0] wdata_q,     wdata_d;
    logic                 busy_q,      busy_d;
    logic                 gap_err_q,   gap_err_d;
    logic                 trunc_err_q, trunc_err_d;
    logic                 ovf_err_q,   ovf_err_d;
    logic [CNT_W-1:0]     pkt_cnt_q,   pkt_cnt_d;

    logic [PKT_WIDTH-1:0] shift_in;
    logic [PKT_WIDTH-1:0] first_bit;
    logic [GAP_W-1:0]     stall_inc;
    logic [GAP_W-1:0]     gap_inc;

    // Right shift with new bit at MSB: after PKT_WIDTH bits the first lands in [0].
    assign shift_in  = {sb.i_ser_data, shift_q[PKT_WIDTH-1:1]};
    assign first_bit = {sb.i_ser_data, (PKT_WIDTH-1)'(0)};
    assign stall_inc = (stall_q   == GAP_W'(GAP_UI)) ? stall_q   : stall_q   + GAP_W'(1);
    assign gap_inc   = (gap_cnt_q == GAP_W'(GAP_UI)) ? gap_cnt_q : gap_cnt_q + GAP_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            stall_q     <= '0;
            gap_cnt_q   <= '0;
            wr_en_q     <= 1'b0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            gap_err_q   <= 1'b0;
            trunc_err_q <= 1'b0;
            ovf_err_q   <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            stall_q     <= stall_d;
            gap_cnt_q   <= gap_cnt_d;
            wr_en_q     <= wr_en_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            gap_err_q   <= gap_err_d;
            trunc_err_q <= trunc_err_d;
            ovf_err_q   <= ovf_err_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        stall_d     = stall_q;
        gap_cnt_d   = gap_cnt_q;
        wr_en_d     = 1'b0;
        wdata_d     = wdata_q;
        gap_err_d   = 1'b0;
        trunc_err_d = 1'b0;
        ovf_err_d   = 1'b0;
        pkt_cnt_d   = pkt_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (sb.i_bit_valid) begin
                    shift_d   = first_bit;
                    bit_cnt_d = BIT_W'(1);
                    stall_d   = '0;
                    state_d   = RECEIVE;
                end
            end
            RECEIVE: begin
                if (sb.i_bit_valid) begin
                    shift_d = shift_in;
                    stall_d = '0;
                    if (bit_cnt_q == BIT_W'(PKT_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        gap_cnt_d = '0;
                        state_d   = GAP;
                        // Never back-pressure: a full FIFO drops the packet.
                        if (!sb.i_fifo_full) begin
                            wr_en_d   = 1'b1;
                            wdata_d   = shift_in;
                            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
                        end else begin
                            ovf_err_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end else begin
                    stall_d = stall_inc;
                    if (stall_inc == GAP_W'(GAP_UI)) begin
                        trunc_err_d = 1'b1;
                        shift_d     = '0;
                        bit_cnt_d   = '0;
                        state_d     = IDLE;
                    end
                end
            end
            GAP: begin
                if (sb.i_bit_valid) begin
                    gap_err_d = 1'b1;
                    shift_d   = first_bit;
                    bit_cnt_d = BIT_W'(1);
                    stall_d   = '0;
                    state_d   = RECEIVE;
                end else begin
                    gap_cnt_d = gap_inc;
                    if (gap_inc == GAP_W'(GAP_UI)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered from next state so it always equals (state_q != IDLE).
    assign busy_d = (state_d != IDLE);

    assign sb.o_fifo_wr_en = wr_en_q;
    assign sb.o_fifo_wdata = wdata_q;
    assign sb.o_rx_busy    = busy_q;
    assign sb.o_gap_err    = gap_err_q;
    assign sb.o_trunc_err  = trunc_err_q;
    assign sb.o_ovf_err    = ovf_err_q;
    assign sb.o_pkt_cnt    = pkt_cnt_q;

endmodule
